// File: rtl/parking_meter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : parking_meter_timer
//  Description : Coin-operated parking meter countdown. Each coin_valid rising
//                edge credits seconds according to coin_code (saturating at
//                MAX_TIME); each sec_tick removes one second down to zero.
//                A registered state (EXPIRED / RUNNING / LOW) and a status LED
//                (steady on when expired, off when running, blinking when low)
//                follow the remaining time.
//  Ports       : clk          - clock, rising edge active
//                reset        - synchronous active-high reset
//                coin_valid   - coin strobe, credited on its 0->1 edge only
//                coin_code    - denomination, sampled with the coin edge
//                sec_tick     - one-cycle pulse per second
//                TotalTime    - remaining paid seconds (registered)
//                LED          - status lamp (registered)
//                state        - 0 EXPIRED, 1 RUNNING, 2 LOW (registered)
//                coin_reject  - one-cycle pulse for a coin edge with bad code
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_meter_timer #(
    parameter int TIME_W      = 14,
    parameter int MAX_TIME    = 9999,
    parameter int ADD1        = 60,
    parameter int ADD2        = 120,
    parameter int ADD3        = 180,
    parameter int ADD4        = 300,
    parameter int LOW_THRESH  = 180,
    parameter int BLINK_TICKS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coin_valid,
    input  logic [2:0]        coin_code,
    input  logic              sec_tick,
    output logic [TIME_W-1:0] TotalTime,
    output logic              LED,
    output logic [1:0]        state,
    output logic              coin_reject
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_expired = 2'd0;
    localparam logic [1:0] c_running = 2'd1;
    localparam logic [1:0] c_low     = 2'd2;

    localparam int c_BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_BLINK_W-1:0] c_blink_last = c_BLINK_W'(BLINK_TICKS - 1);

    localparam logic [TIME_W:0]   c_max_wide = (TIME_W+1)'(MAX_TIME);
    localparam logic [TIME_W-1:0] c_max      = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] c_thresh   = TIME_W'(LOW_THRESH);

    localparam logic [TIME_W:0] c_add1 = (TIME_W+1)'(ADD1);
    localparam logic [TIME_W:0] c_add2 = (TIME_W+1)'(ADD2);
    localparam logic [TIME_W:0] c_add3 = (TIME_W+1)'(ADD3);
    localparam logic [TIME_W:0] c_add4 = (TIME_W+1)'(ADD4);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [TIME_W-1:0]    r_total;
    logic [1:0]           r_state;
    logic                 r_led;
    logic                 r_reject;
    logic                 r_coin_prev;
    logic [c_BLINK_W-1:0] r_blink_cnt;

    // ------------------------------------------------------------------
    // Combinational next-value logic
    // ------------------------------------------------------------------
    logic              w_coin_evt;
    logic [TIME_W:0]   w_add;
    logic              w_code_bad;
    logic [TIME_W:0]   w_sum;
    logic [TIME_W-1:0] w_sat;
    logic [TIME_W-1:0] w_next_total;
    logic [1:0]        w_next_state;

    // Edge detect: the history register resets to 1 so a strobe already
    // high when reset releases is not mistaken for a fresh coin.
    assign w_coin_evt = coin_valid & ~r_coin_prev;

    always_comb begin
        w_add      = '0;
        w_code_bad = 1'b0;
        case (coin_code)
            3'd1:    w_add = c_add1;
            3'd2:    w_add = c_add2;
            3'd3:    w_add = c_add3;
            3'd4:    w_add = c_add4;
            default: w_code_bad = 1'b1;
        endcase
    end

    // One extra bit of headroom so the saturation compare never sees a wrap.
    assign w_sum = {1'b0, r_total} + (w_coin_evt ? w_add : '0);
    assign w_sat = (w_sum > c_max_wide) ? c_max : w_sum[TIME_W-1:0];

    // Decrement is applied after credit/saturation, and only when nonzero.
    assign w_next_total = (sec_tick && (w_sat != '0)) ? (w_sat - TIME_W'(1)) : w_sat;

    always_comb begin
        w_next_state = c_running;
        if (w_next_total == '0) begin
            w_next_state = c_expired;
        end else if (w_next_total <= c_thresh) begin
            w_next_state = c_low;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total     <= '0;
            r_state     <= c_expired;
            r_led       <= 1'b1;
            r_reject    <= 1'b0;
            r_coin_prev <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            r_total     <= w_next_total;
            r_state     <= w_next_state;
            r_reject    <= w_coin_evt & w_code_bad;
            r_coin_prev <= coin_valid;

            case (w_next_state)
                c_expired: begin
                    r_led       <= 1'b1;
                    r_blink_cnt <= '0;
                end
                c_low: begin
                    if (r_state != c_low) begin
                        // Fresh entry: restart the blink phase with lamp on.
                        r_led       <= 1'b1;
                        r_blink_cnt <= '0;
                    end else if (sec_tick) begin
                        if (r_blink_cnt == c_blink_last) begin
                            r_led       <= ~r_led;
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
                        end
                    end
                end
                default: begin
                    r_led       <= 1'b0;
                    r_blink_cnt <= '0;
                end
            endcase
        end
    end

    assign TotalTime   = r_total;
    assign state       = r_state;
    assign LED         = r_led;
    assign coin_reject = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_parking_meter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_meter_timer
//  Description : Self-checking bench for parking_meter_timer with default
//                parameters. A table of per-cycle vectors plus hand-written
//                sequences drive the DUT; expected outputs are queued when
//                stimulus is applied and checked one clock later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_meter_timer;

    localparam logic [1:0] c_exp = 2'd0;
    localparam logic [1:0] c_run = 2'd1;
    localparam logic [1:0] c_low = 2'd2;

    logic        clk;
    logic        reset;
    logic        coin_valid;
    logic [2:0]  coin_code;
    logic        sec_tick;
    logic [13:0] TotalTime;
    logic        LED;
    logic [1:0]  state;
    logic        coin_reject;

    parking_meter_timer dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .sec_tick    (sec_tick),
        .TotalTime   (TotalTime),
        .LED         (LED),
        .state       (state),
        .coin_reject (coin_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cv;
        logic [2:0]  code;
        logic        tick;
        logic [13:0] total;
        logic [1:0]  st;
        logic        led;
        logic        rej;
    } vec_t;

    typedef struct {
        logic [13:0] total;
        logic [1:0]  st;
        logic        led;
        logic        rej;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_total;
    int   n_bad;

    // Apply one cycle of stimulus, queue its expected result, then check it
    // one clock later (sampled 1 time unit after the active edge).
    task automatic step(input logic rst, input logic cv, input logic [2:0] code,
                        input logic tick, input logic [13:0] total,
                        input logic [1:0] st, input logic led, input logic rej,
                        input string name);
        exp_t e;
        exp_t got;
        e.total = total;
        e.st    = st;
        e.led   = led;
        e.rej   = rej;
        exp_q.push_back(e);
        reset      = rst;
        coin_valid = cv;
        coin_code  = code;
        sec_tick   = tick;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        n_total++;
        if (TotalTime !== got.total || state !== got.st ||
            LED !== got.led || coin_reject !== got.rej) begin
            n_bad++;
            $display("FAIL %s: got total=%0d state=%0d led=%b rej=%b, want total=%0d state=%0d led=%b rej=%b",
                     name, TotalTime, state, LED, coin_reject,
                     got.total, got.st, got.led, got.rej);
        end
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        coin_valid = 1'b0;
        coin_code  = 3'd0;
        sec_tick   = 1'b0;

        //                rst   cv    code  tick  total   st     led   rej
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0}); // reset state
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 1'b0, 14'd60,  c_low, 1'b1, 1'b0}); // code 1 -> LOW
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd60,  c_low, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 14'd59,  c_low, 1'b0, 1'b0}); // blink
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 14'd58,  c_low, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd58,  c_low, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd4, 1'b0, 14'd300, c_run, 1'b0, 1'b0}); // 4,4,3
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd300, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd4, 1'b0, 14'd600, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd600, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd3, 1'b0, 14'd780, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd780, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 14'd900, c_run, 1'b0, 1'b0}); // held 5 cycles
        tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd6, 1'b0, 14'd900, c_run, 1'b0, 1'b1}); // code 6 reject
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd0, 1'b0, 14'd900, c_run, 1'b0, 1'b1}); // code 0 reject
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd900, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 1'b1, 14'd959, c_run, 1'b0, 1'b0}); // coin + tick
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd959, c_run, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd4, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0}); // reset beats coin
        tbl.push_back('{1'b0, 1'b1, 3'd4, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0}); // held through release
        tbl.push_back('{1'b0, 1'b1, 3'd4, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 1'b0, 14'd60,  c_low, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd1, 1'b1, 14'd59,  c_low, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 14'd0,   c_exp, 1'b1, 1'b0}); // reset mid-count
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].cv, tbl[i].code, tbl[i].tick,
                 tbl[i].total, tbl[i].st, tbl[i].led, tbl[i].rej,
                 $sformatf("vec%0d", i));
        end

        // ---- Saturation: build 9900, then code 4 -> 9999, then coin+tick -> 9998
        step(1'b1, 1'b0, 3'd0, 1'b0, 14'd0, c_exp, 1'b1, 1'b0, "sat_rst");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd0, c_exp, 1'b1, 1'b0, "sat_idle");
        for (int k = 1; k <= 33; k++) begin
            step(1'b0, 1'b1, 3'd4, 1'b0, 14'(300 * k), c_run, 1'b0, 1'b0, "sat_build");
            step(1'b0, 1'b0, 3'd0, 1'b0, 14'(300 * k), c_run, 1'b0, 1'b0, "sat_build_low");
        end
        step(1'b0, 1'b1, 3'd4, 1'b0, 14'd9999, c_run, 1'b0, 1'b0, "sat_9999");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd9999, c_run, 1'b0, 1'b0, "sat_hold");
        step(1'b0, 1'b1, 3'd4, 1'b1, 14'd9998, c_run, 1'b0, 1'b0, "sat_coin_tick");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd9998, c_run, 1'b0, 1'b0, "sat_after");

        // ---- Countdown 300 -> 0: RUNNING->LOW at 180, blink, LOW->EXPIRED, no underflow
        step(1'b1, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0, "cd_rst");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0, "cd_idle");
        step(1'b0, 1'b1, 3'd4, 1'b0, 14'd300, c_run, 1'b0, 1'b0, "cd_coin");
        for (int v = 299; v >= 1; v--) begin
            if (v > 180)
                step(1'b0, 1'b0, 3'd0, 1'b1, 14'(v), c_run, 1'b0, 1'b0, "cd_running");
            else
                step(1'b0, 1'b0, 3'd0, 1'b1, 14'(v), c_low,
                     ((180 - v) % 2 == 0) ? 1'b1 : 1'b0, 1'b0, "cd_low");
        end
        step(1'b0, 1'b0, 3'd0, 1'b1, 14'd0, c_exp, 1'b1, 1'b0, "cd_expire");
        step(1'b0, 1'b0, 3'd0, 1'b1, 14'd0, c_exp, 1'b1, 1'b0, "cd_no_underflow");

        // ---- Reset at 500 with coin_valid high across release
        step(1'b1, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0, "r5_rst");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd0,   c_exp, 1'b1, 1'b0, "r5_idle");
        step(1'b0, 1'b1, 3'd4, 1'b0, 14'd300, c_run, 1'b0, 1'b0, "r5_c4");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd300, c_run, 1'b0, 1'b0, "r5_gap1");
        step(1'b0, 1'b1, 3'd3, 1'b0, 14'd480, c_run, 1'b0, 1'b0, "r5_c3");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd480, c_run, 1'b0, 1'b0, "r5_gap2");
        step(1'b0, 1'b1, 3'd1, 1'b0, 14'd540, c_run, 1'b0, 1'b0, "r5_c1");
        for (int v = 539; v >= 500; v--)
            step(1'b0, 1'b0, 3'd0, 1'b1, 14'(v), c_run, 1'b0, 1'b0, "r5_tick");
        step(1'b1, 1'b1, 3'd4, 1'b1, 14'd0, c_exp, 1'b1, 1'b0, "r5_reset");
        step(1'b1, 1'b1, 3'd4, 1'b0, 14'd0, c_exp, 1'b1, 1'b0, "r5_reset_hold");
        step(1'b0, 1'b1, 3'd4, 1'b0, 14'd0, c_exp, 1'b1, 1'b0, "r5_release");
        step(1'b0, 1'b1, 3'd4, 1'b0, 14'd0, c_exp, 1'b1, 1'b0, "r5_still_high");
        step(1'b0, 1'b0, 3'd0, 1'b0, 14'd0, c_exp, 1'b1, 1'b0, "r5_drop");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
